// File: rtl/light_seq_ctrl.sv
// Tail-light request sequencer: divides the clock into lamp-step intervals,
// blinks granted turn signals over four intervals and arbitrates steady holds.
module light_seq_ctrl #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left_req,
    input  logic right_req,
    input  logic brake_req,
    input  logic fog_req,
    input  logic alarm_req,
    output logic step,
    output logic left,
    output logic right,
    output logic brake,
    output logic fog,
    output logic alarm,
    output logic busy
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_HOLD} state_t;
    typedef enum logic [2:0] {L_NONE, L_LEFT, L_RIGHT, L_BRAKE, L_FOG, L_ALARM} line_t;

    logic [CW-1:0] div_q, div_d;
    state_t        state_q, state_d;
    line_t         line_q, line_d;
    logic [1:0]    phase_q, phase_d;
    logic          pend_l_q, pend_l_d;
    logic          pend_r_q, pend_r_d;
    logic          rr_q, rr_d;
    logic          left_q, right_q, brake_q, fog_q, alarm_q;
    logic          decide;
    logic          grant_left;

    assign step = (div_q == DIV_LAST);
    assign busy = (state_q != S_IDLE);

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        div_d      = step ? '0 : div_q + 1'b1;
        state_d    = state_q;
        line_d     = line_q;
        phase_d    = phase_q;
        rr_d       = rr_q;
        pend_l_d   = pend_l_q | left_req;
        pend_r_d   = pend_r_q | right_req;
        decide     = 1'b0;
        grant_left = pend_l_q && !(pend_r_q && rr_q);

        if (step) begin
            unique case (state_q)
                S_IDLE: decide = 1'b1;
                S_TURN: begin
                    if (phase_q == 2'd3) begin
                        decide = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        line_d  = L_NONE;
                    end
                end
                S_HOLD: begin
                    if (alarm_req) begin
                        line_d = L_ALARM;
                    end else if (brake_req) begin
                        line_d = L_BRAKE;
                    end else if (line_q == L_FOG && (pend_l_q || pend_r_q)) begin
                        // Fog yields to a waiting turn via one dark interval.
                        state_d = S_IDLE;
                        line_d  = L_NONE;
                    end else if (fog_req) begin
                        line_d = L_FOG;
                    end else begin
                        state_d = S_IDLE;
                        line_d  = L_NONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    line_d  = L_NONE;
                end
            endcase
        end

        if (decide) begin
            phase_d = 2'd0;
            if (alarm_req) begin
                state_d = S_HOLD;
                line_d  = L_ALARM;
            end else if (brake_req) begin
                state_d = S_HOLD;
                line_d  = L_BRAKE;
            end else if (pend_l_q || pend_r_q) begin
                state_d = S_TURN;
                if (grant_left) begin
                    line_d   = L_LEFT;
                    pend_l_d = 1'b0;
                    rr_d     = 1'b1;
                end else begin
                    line_d   = L_RIGHT;
                    pend_r_d = 1'b0;
                    rr_d     = 1'b0;
                end
            end else if (fog_req) begin
                state_d = S_HOLD;
                line_d  = L_FOG;
            end else begin
                state_d = S_IDLE;
                line_d  = L_NONE;
            end
        end
    end

    // NOTE: reset is synchronous, so it only takes effect at a rising clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q    <= '0;
            state_q  <= S_IDLE;
            line_q   <= L_NONE;
            phase_q  <= 2'd0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            rr_q     <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            brake_q  <= 1'b0;
            fog_q    <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            line_q   <= line_d;
            phase_q  <= phase_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            rr_q     <= rr_d;
            left_q   <= (line_d == L_LEFT);
            right_q  <= (line_d == L_RIGHT);
            brake_q  <= (line_d == L_BRAKE);
            fog_q    <= (line_d == L_FOG);
            alarm_q  <= (line_d == L_ALARM);
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign brake = brake_q;
    assign fog   = fog_q;
    assign alarm = alarm_q;

endmodule

// File: doc/light_seq_ctrl.md
LIGHT_SEQ_CTRL -- requirements
Module: light_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per lamp step (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-004 left_req, right_req  input  1 each  driver turn requests; pulses of any length.
REQ-005 brake_req, fog_req, alarm_req  input  1 each  driver level requests.
REQ-006 step  output  1  one-cycle strobe; downstream tail-light FSM advances only on edges where step=1.
REQ-007 left, right, brake, fog, alarm  output  1 each  registered request lines presented to the tail-light FSM.
REQ-008 busy  output  1  high when state is not IDLE.

Function
REQ-009 Divider div_cnt counts 0..TICK_DIV-1 and wraps; step SHALL be high exactly when div_cnt = TICK_DIV-1.
REQ-010 Interval = TICK_DIV cycles ending at a step edge; outputs change only at step edges and stay stable for the following interval.
REQ-011 At most one of left/right/brake/fog/alarm SHALL be high in any cycle.
REQ-012 pend_l/pend_r set in any cycle where left_req/right_req = 1; cleared only when that turn is granted (grant wins over same-cycle set).
REQ-013 States: IDLE, TURN, HOLD; rr flag selects next turn when both pending (0 = left first).
REQ-014 Decision D at a step edge: alarm_req -> HOLD(alarm); else brake_req -> HOLD(brake); else pending turn -> TURN; else fog_req -> HOLD(fog); else IDLE, outputs 0.
REQ-015 IDLE: D evaluated at every step edge.
REQ-016 TURN grant: selected line = 1 for one interval, then 0 for three intervals (FSM NULL->x1->x2->x3->NULL); D at end of 4th interval.
REQ-017 TURN SHALL NOT be preempted by any request; new requests wait (turn pulses stay latched).
REQ-018 Turn grant clears the granted pending bit and sets rr to the other side; single pending side is granted regardless of rr.
REQ-019 HOLD(k): line k held high; at each step edge, if alarm_req/brake_req/fog_req selects kind j by priority alarm>brake>fog, switch directly to HOLD(j).
REQ-020 HOLD(fog) with a pending turn and no alarm_req/brake_req: go IDLE, outputs 0 for one interval (FSM returns NULL), then D grants the turn.
REQ-021 HOLD(brake)/HOLD(alarm) block turns; pending bits retained.
REQ-022 HOLD with no hold request asserted: go IDLE, outputs 0.
REQ-023 Continuous alarm_req: alarm held high; FSM alternation ALARM/NULL is expected flashing, not a controller fault.
REQ-024 busy combinational from state; step combinational from div_cnt; all other outputs registered.

Reset
REQ-025 reset=0 at a rising edge: div_cnt=0, state IDLE, pend_l=pend_r=0, rr=0, all request outputs 0.
REQ-026 Resulting values: step=0, busy=0 in the first cycle after reset; first step TICK_DIV-1 cycles after reset release.
REQ-027 Reset mid-TURN or mid-HOLD SHALL abort immediately with no residual output or pending request.

Verification
REQ-028 TICK_DIV=4, reset released at cycle 0 -> step high at cycles 3, 7, 11; busy=0, outputs 0 throughout.
REQ-029 left_req one-cycle pulse at cycle 1 -> left=1 cycles 4-7, left=0 cycles 8-19, busy=1 cycles 4-19, IDLE at cycle 20.
REQ-030 left_req and right_req both pulsed at cycle 1 -> left sequence first, then right=1 for the interval starting cycle 20; rr toggles each grant.
REQ-031 fog_req held, right_req pulse during HOLD(fog) -> fog drops at next step edge, zero interval, then right granted; fog resumes after right's 4 intervals.
REQ-032 brake_req held during a left TURN -> brake asserted only after the 4th interval; alarm_req raised during HOLD(brake) -> alarm replaces brake at next step edge with no zero interval.
REQ-033 reset=0 mid-TURN with pend_r set -> next cycle all outputs 0, busy=0, pend_r cleared; no right grant after release.
